ram8_seq_ctrl: RTL



---
 rtl/ram8_seq_pkg.sv | 17 +
 rtl/ram8_seq_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/ram8_seq_pkg.sv
// ram8_seq_pkg: state encoding, command byte fields and RAM8 geometry for ram8_seq_ctrl
package ram8_seq_pkg;
    localparam int NUM_WORDS      = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_W         = 3;
    localparam int CMD_WR_BIT     = 7;
    localparam int CMD_LEN_LSB    = 4;
    localparam int CMD_LEN_W      = 3;
    localparam int CMD_ADDR_LSB   = 0;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WDATA    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RD_SEND  = 3'd4
    } state_t;
endpackage

// File: rtl/ram8_seq_ctrl.sv
// ram8_seq_ctrl: byte-stream command front end sequencing word bursts into a RAM8 macro
module ram8_seq_ctrl
    import ram8_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_data,
    output logic              busy,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_di,
    input  logic [31:0]       ram_do
);
    state_t            state;
    logic              up;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        burst;
    logic [1:0]        idx;
    logic [31:0]       shift;
    logic              cmd_fire;
    logic              rsp_fire;
    logic              last_byte;
    // up holds cmd_ready low through reset and releases it on the first clock after
    assign cmd_ready = up && (state == IDLE || state == WDATA);
    assign rsp_valid = state == RD_SEND;
    assign rsp_data  = shift[7:0];
    assign busy      = state != IDLE;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign last_byte = idx == 2'(BYTES_PER_WORD - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            up       <= 1'b0;
            addr     <= '0;
            burst    <= '0;
            idx      <= '0;
            shift    <= '0;
            ram_en   <= 1'b0;
            ram_we   <= '0;
            ram_addr <= '0;
            ram_di   <= '0;
        end else begin
            up     <= 1'b1;
            ram_en <= 1'b0;
            ram_we <= '0;
            case (state)
                IDLE: if (cmd_fire) begin
                    addr  <= cmd_data[CMD_ADDR_LSB +: ADDR_W];
                    burst <= cmd_data[CMD_LEN_LSB +: CMD_LEN_W];
                    idx   <= '0;
                    if (cmd_data[CMD_WR_BIT]) begin
                        state <= WDATA;
                    end else begin
                        state    <= RD_ISSUE;
                        ram_en   <= 1'b1;
                        ram_addr <= cmd_data[CMD_ADDR_LSB +: ADDR_W];
                    end
                end
                WDATA: if (cmd_fire) begin
                    ram_en   <= 1'b1;
                    ram_we   <= 4'b0001 << idx;
                    ram_addr <= addr;
                    ram_di   <= 32'(cmd_data) << {idx, 3'b000};
                    idx      <= idx + 2'd1;
                    if (last_byte) begin
                        addr  <= addr + 3'd1;
                        burst <= burst - 3'd1;
                        if (burst == '0) state <= IDLE;
                    end
                end
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    shift <= ram_do;
                    state <= RD_SEND;
                end
                RD_SEND: if (rsp_fire) begin
                    shift <= shift >> 8;
                    idx   <= idx + 2'd1;
                    if (last_byte) begin
                        addr  <= addr + 3'd1;
                        burst <= burst - 3'd1;
                        if (burst == '0) begin
                            state <= IDLE;
                        end else begin
                            state    <= RD_ISSUE;
                            ram_en   <= 1'b1;
                            ram_addr <= addr + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
